// File: rtl/ramen_shop_if.sv
// Order/report bus of the ramen stall order engine.
// The stall side (master) drives orders and the session flag; the engine (slave) answers.
interface ramen_shop_if;
  logic        in_valid;
  logic        selling;
  logic        portion;
  logic [1:0]  ramen_type;
  logic        out_valid_order;
  logic        success;
  logic        out_valid_tot;
  logic [14:0] total_gain;
  logic [27:0] sold_num;

  modport master (
    output in_valid, selling, portion, ramen_type,
    input  out_valid_order, success, out_valid_tot, total_gain, sold_num
  );

  modport slave (
    input  in_valid, selling, portion, ramen_type,
    output out_valid_order, success, out_valid_tot, total_gain, sold_num
  );
endinterface

// File: rtl/ramen_shop.sv
// Ramen stall order engine: two-beat orders checked against five ingredient stocks,
// one-cycle accept/reject answer, and a per-session revenue / sold-count report.
module ramen_shop (
  input  logic         clk,
  input  logic         rst_n,
  ramen_shop_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StGetPortion, StRespond, StReport} state_e;

  // Ingredient index: 0 noodle, 1 broth, 2 tonkotsu soup, 3 soy sauce, 4 miso.
  localparam int unsigned NumIngr = 5;
  localparam logic [NumIngr-1:0][15:0] FullStock = {
    16'd1000, 16'd1000, 16'd9000, 16'd41000, 16'd12000
  };

  state_e                    r_state, w_state_nxt;
  logic                      r_sell_prev;
  logic [1:0]                r_type;
  logic                      r_success;
  logic [NumIngr-1:0][15:0]  r_stock;
  logic [NumIngr-1:0][15:0]  w_need;
  logic [14:0]               r_gain;
  logic [3:0][6:0]           r_cnt;
  logic [14:0]               w_price;
  logic                      w_sell_rise, w_sell_fall;
  logic                      w_enough, w_beat1, w_commit;

  assign w_sell_rise = io_bus.selling & ~r_sell_prev;
  assign w_sell_fall = ~io_bus.selling & r_sell_prev;

  // Recipe lookup from the latched type and the portion on the second beat.
  always_comb begin
    w_need    = '0;
    w_need[0] = io_bus.portion ? 16'd150 : 16'd100;
    if (r_type == 2'd2) begin
      w_need[1] = io_bus.portion ? 16'd650 : 16'd400;
    end else begin
      w_need[1] = io_bus.portion ? 16'd500 : 16'd300;
    end
    unique case (r_type)
      2'd0: w_need[2] = io_bus.portion ? 16'd200 : 16'd150;
      2'd1: begin
        w_need[2] = io_bus.portion ? 16'd150 : 16'd100;
        w_need[3] = io_bus.portion ? 16'd50  : 16'd30;
      end
      2'd2: w_need[4] = io_bus.portion ? 16'd50 : 16'd30;
      2'd3: begin
        w_need[3] = io_bus.portion ? 16'd25 : 16'd15;
        w_need[4] = io_bus.portion ? 16'd25 : 16'd15;
      end
      default: ;
    endcase
  end

  assign w_price = r_type[0] ? 15'd250 : 15'd200;

  always_comb begin
    w_enough = 1'b1;
    for (int i = 0; i < NumIngr; i++) begin
      if (r_stock[i] < w_need[i]) begin
        w_enough = 1'b0;
      end
    end
  end

  assign w_beat1  = io_bus.in_valid &
                    (((r_state == StIdle) & ~w_sell_fall) | (r_state == StReport));
  assign w_commit = (r_state == StGetPortion) & w_enough;

  always_comb begin
    w_state_nxt            = r_state;
    io_bus.out_valid_order = 1'b0;
    io_bus.success         = 1'b0;
    io_bus.out_valid_tot   = 1'b0;
    io_bus.total_gain      = '0;
    io_bus.sold_num        = '0;
    unique case (r_state)
      StIdle: begin
        if (w_sell_fall) begin
          w_state_nxt = StReport;
        end else if (io_bus.in_valid) begin
          w_state_nxt = StGetPortion;
        end
      end
      StGetPortion: w_state_nxt = StRespond;
      StRespond: begin
        w_state_nxt            = StIdle;
        io_bus.out_valid_order = 1'b1;
        io_bus.success         = r_success;
      end
      StReport: begin
        w_state_nxt          = io_bus.in_valid ? StGetPortion : StIdle;
        io_bus.out_valid_tot = 1'b1;
        io_bus.total_gain    = r_gain;
        io_bus.sold_num      = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sell_prev <= 1'b0;
      r_type      <= '0;
      r_success   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sell_prev <= io_bus.selling;
      if (w_beat1) begin
        r_type <= io_bus.ramen_type;
      end
      if (r_state == StGetPortion) begin
        r_success <= w_enough;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stock <= FullStock;
    end else if (w_sell_rise) begin
      r_stock <= FullStock;
    end else if (w_commit) begin
      for (int i = 0; i < NumIngr; i++) begin
        r_stock[i] <= r_stock[i] - w_need[i];
      end
    end
  end

  // Totals clear on the report cycle so the next session starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gain <= '0;
      r_cnt  <= '0;
    end else if (r_state == StReport) begin
      r_gain <= '0;
      r_cnt  <= '0;
    end else if (w_commit) begin
      r_gain         <= r_gain + w_price;
      r_cnt[r_type]  <= r_cnt[r_type] + 7'd1;
    end
  end

endmodule

// File: tb/tb_ramen_shop.sv
// Directed self-checking bench for ramen_shop: orders, stock exhaustion and session reports.
module tb_ramen_shop;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ramen_shop_if bus ();

  ramen_shop dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two beats, then check the response cycle; returns on the cycle after the response.
  task automatic order(input logic [1:0] t, input logic p, input logic exp_ok, input string tag);
    bus.in_valid   = 1'b1;
    bus.ramen_type = t;
    bus.portion    = ~p;
    step();
    bus.portion    = p;
    bus.ramen_type = ~t;
    chk({tag, " early_resp"}, bus.out_valid_order, 0);
    step();
    bus.in_valid = 1'b0;
    chk({tag, " resp_valid"}, bus.out_valid_order, 1);
    chk({tag, " success"}, bus.success, exp_ok);
    step();
  endtask

  task automatic start_session();
    bus.selling = 1'b1;
    step();
    step();
  endtask

  task automatic end_session(input logic [14:0] gain, input logic [27:0] sold, input string tag);
    bus.selling = 1'b0;
    step();
    chk({tag, " tot_valid"}, bus.out_valid_tot, 1);
    chk({tag, " total_gain"}, bus.total_gain, gain);
    chk({tag, " sold_num"}, bus.sold_num, sold);
    step();
    chk({tag, " tot_valid_drop"}, bus.out_valid_tot, 0);
    chk({tag, " gain_zero_after"}, bus.total_gain, 0);
    chk({tag, " sold_zero_after"}, bus.sold_num, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.selling    = 1'b0;
    bus.portion    = 1'b0;
    bus.ramen_type = 2'd0;
    #1;
    chk("rst out_valid_order", bus.out_valid_order, 0);
    chk("rst success", bus.success, 0);
    chk("rst out_valid_tot", bus.out_valid_tot, 0);
    chk("rst total_gain", bus.total_gain, 0);
    chk("rst sold_num", bus.sold_num, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: single big MISO_SOY
    start_session();
    order(2'd3, 1'b1, 1'b1, "t1 ms_big");
    end_session(15'd250, 28'h0000001, "t1");

    // 2: miso runs out after 33 small MISO
    start_session();
    for (int i = 0; i < 40; i++) order(2'd2, 1'b0, (i < 33), "t2 miso_small");
    end_session(15'd6600, {7'd0, 7'd0, 7'd33, 7'd0}, "t2");

    // 3: soy used up exactly by 20 big TONKOTSU_SOY
    start_session();
    for (int i = 0; i < 21; i++) order(2'd1, 1'b1, (i < 20), "t3 ts_big");
    order(2'd3, 1'b0, 1'b0, "t3 ms_small_nosoy");
    order(2'd2, 1'b0, 1'b1, "t3 miso_small");
    end_session(15'd5200, {7'd0, 7'd20, 7'd1, 7'd0}, "t3");

    // 4: tonkotsu soup runs out after 60 small TONKOTSU
    start_session();
    for (int i = 0; i < 120; i++) order(2'd0, 1'b0, (i < 60), "t4 tk_small");
    end_session(15'd12000, {7'd60, 7'd0, 7'd0, 7'd0}, "t4");

    // 5: back-to-back sessions, each restocked and reporting only its own orders
    start_session();
    order(2'd0, 1'b1, 1'b1, "t5a tk_big_restocked");
    end_session(15'd200, {7'd1, 7'd0, 7'd0, 7'd0}, "t5a");
    start_session();
    order(2'd1, 1'b0, 1'b1, "t5b ts_small");
    order(2'd2, 1'b1, 1'b1, "t5b miso_big");
    end_session(15'd450, {7'd0, 7'd1, 7'd1, 7'd0}, "t5b");

    // 6: reset between beats aborts the order and the session
    start_session();
    order(2'd0, 1'b0, 1'b1, "t6 pre_reset");
    bus.in_valid   = 1'b1;
    bus.ramen_type = 2'd3;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6 rst out_valid_order", bus.out_valid_order, 0);
    chk("t6 rst out_valid_tot", bus.out_valid_tot, 0);
    bus.in_valid = 1'b0;
    bus.selling  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6 no_resp_after_reset", bus.out_valid_order, 0);
      chk("t6 no_report_after_reset", bus.out_valid_tot, 0);
    end
    start_session();
    order(2'd3, 1'b1, 1'b1, "t6 ms_big");
    end_session(15'd250, 28'h0000001, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
